// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with one-cold row drive, press/release debounce and single-key lockout.
// Optional auto-repeat of the held key is compiled in when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CYC = 200000,
    parameter int REPEAT_CYC   = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);

    if (SCAN_DIV < 2 || DEBOUNCE_CYC < 2 || REPEAT_CYC < 2) begin : g_param_check
        $error("keypad_scanner: SCAN_DIV, DEBOUNCE_CYC and REPEAT_CYC must each be at least 2");
    end

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [1:0]       row_idx_r, row_idx_s;
    logic [1:0]       col_idx_r, col_idx_s;
    logic [3:0]       row_r, row_s;
    logic [3:0]       key_code_r, key_code_s;
    logic             key_valid_r, key_valid_s;
    logic             key_held_r, key_held_s;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYC + 1);
    localparam logic [REP_W-1:0] REP_ZERO = REP_W'(0);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);
    logic [REP_W-1:0] rep_cnt_r, rep_cnt_s;
`endif

    function automatic logic is_one_cold(input logic [3:0] v);
        logic [2:0] zeros;
        zeros = 3'd0;
        for (int i = 0; i < 4; i++) begin
            zeros = zeros + {2'b00, ~v[i]};
        end
        return (zeros == 3'd1);
    endfunction

    function automatic logic [1:0] zero_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] one_cold(input logic [1:0] idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

    // Next-state, counter and output decode for the scan/debounce FSM.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        row_idx_s   = row_idx_r;
        col_idx_s   = col_idx_r;
        key_code_s  = key_code_r;
        key_valid_s = 1'b0;
        key_held_s  = key_held_r;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_s   = rep_cnt_r;
`endif
        case (state_r)
            SCAN: begin
                if (cnt_r == SCAN_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (is_one_cold(col)) begin
                        col_idx_s = zero_index(col);
                        state_s   = PRESS_DB;
                    end else begin
                        row_idx_s = row_idx_r + 2'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            PRESS_DB: begin
                if (col != one_cold(col_idx_r)) begin
                    state_s   = SCAN;
                    cnt_s     = CNT_ZERO;
                    row_idx_s = row_idx_r + 2'd1;
                end else if (cnt_r == DB_LAST) begin
                    key_code_s  = {row_idx_r, col_idx_r};
                    key_valid_s = 1'b1;
                    key_held_s  = 1'b1;
                    state_s     = HELD;
                    cnt_s       = CNT_ZERO;
`ifdef KEYPAD_REPEAT_EN
                    rep_cnt_s   = REP_ZERO;
`endif
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            // Only the latched column matters here, so a second key cannot be reported.
            HELD: begin
                if (col[col_idx_r]) begin
                    cnt_s   = CNT_ZERO;
                    state_s = RELEASE_DB;
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    if (rep_cnt_r == REP_LAST) begin
                        key_valid_s = 1'b1;
                        rep_cnt_s   = REP_ZERO;
                    end else begin
                        rep_cnt_s = rep_cnt_r + REP_ONE;
                    end
`else
                    state_s = HELD;
`endif
                end
            end
            RELEASE_DB: begin
                if (!col[col_idx_r]) begin
                    state_s = HELD;
                    cnt_s   = CNT_ZERO;
`ifdef KEYPAD_REPEAT_EN
                    rep_cnt_s = REP_ZERO;
`endif
                end else if (cnt_r == DB_LAST) begin
                    key_held_s = 1'b0;
                    state_s    = SCAN;
                    cnt_s      = CNT_ZERO;
                    row_idx_s  = row_idx_r + 2'd1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = SCAN;
                cnt_s   = CNT_ZERO;
            end
        endcase
        row_s = one_cold(row_idx_s);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= SCAN;
            cnt_r       <= CNT_ZERO;
            row_idx_r   <= 2'd0;
            col_idx_r   <= 2'd0;
            row_r       <= 4'b1110;
            key_code_r  <= 4'b0000;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_r   <= REP_ZERO;
`endif
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            row_idx_r   <= row_idx_s;
            col_idx_r   <= col_idx_s;
            row_r       <= row_s;
            key_code_r  <= key_code_s;
            key_valid_r <= key_valid_s;
            key_held_r  <= key_held_s;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_r   <= rep_cnt_s;
`endif
        end
    end

    assign row       = row_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed vector table, hand-written corner sequences,
// and randomized key presses through a physical keypad model checked against an arithmetic timeline.
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DB       = 8;
    localparam int REP      = 32;
`ifdef KEYPAD_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic       direct_mode;
    logic [3:0] col_drv;
    logic       key_down;
    logic [1:0] key_r;
    logic [1:0] key_c;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         cycles;
        logic [3:0] col;
        logic [3:0] row;
        logic       valid;
        logic       held;
        logic [3:0] code;
    } vec_t;

    vec_t vecs[$];

    keypad_scanner #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CYC(DB),
        .REPEAT_CYC  (REP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .col      (col),
        .row      (row),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Either a directly forced column value or a single pressed key that pulls its column low
    // whenever its row is driven.
    always_comb begin
        col = 4'b1111;
        if (direct_mode) begin
            col = col_drv;
        end else if (key_down && (row[key_r] == 1'b0)) begin
            col[key_c] = 1'b0;
        end
    end

    function automatic logic [3:0] row_of(input int idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << (idx % 4));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] er, input logic ev,
                         input logic eh, input logic [3:0] ec);
        total++;
        if (row !== er || key_valid !== ev || key_held !== eh || key_code !== ec) begin
            bad++;
            $display("FAIL %s: got row=%b valid=%b held=%b code=%b, want row=%b valid=%b held=%b code=%b",
                     name, row, key_valid, key_held, key_code, er, ev, eh, ec);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int   n;
        int   p;
        int   d;
        int   a;
        int   rl;
        int   last;
        int   pulses;
        int   ridx;
        logic ev;
        logic eh;
        logic [3:0] ec;

        reset       = 1'b0;
        direct_mode = 1'b1;
        col_drv     = 4'b1111;
        key_down    = 1'b0;
        key_r       = 2'd0;
        key_c       = 2'd0;

        // Edge n counts clocks after the reset edge; row after edge n while scanning is (n/4)%4.
        // Idle scan, edges 1..32.
        vecs.push_back('{3, 4'b1111, 4'b1110, 1'b0, 1'b0, 4'b0000});
        for (int k = 1; k < 8; k++) begin
            vecs.push_back('{4, 4'b1111, row_of(k), 1'b0, 1'b0, 4'b0000});
        end
        vecs.push_back('{1, 4'b1111, 4'b1110, 1'b0, 1'b0, 4'b0000});
        // Press col 2 so it is sampled on row 1 at edge 40; accepted 8 edges later at 48.
        vecs.push_back('{3,  4'b1111, 4'b1110, 1'b0, 1'b0, 4'b0000});
        vecs.push_back('{1,  4'b1111, 4'b1101, 1'b0, 1'b0, 4'b0000});
        vecs.push_back('{11, 4'b1011, 4'b1101, 1'b0, 1'b0, 4'b0000});
        vecs.push_back('{1,  4'b1011, 4'b1101, 1'b1, 1'b1, 4'b0110});
        vecs.push_back('{6,  4'b1011, 4'b1101, 1'b0, 1'b1, 4'b0110});
        // Release bounce: 4 edges of 1111, then back to HELD with no pulse.
        vecs.push_back('{4,  4'b1111, 4'b1101, 1'b0, 1'b1, 4'b0110});
        vecs.push_back('{3,  4'b1011, 4'b1101, 1'b0, 1'b1, 4'b0110});
        // Clean release: the edge that sees 1111 plus 8 debounce edges, then scan resumes at row 2.
        vecs.push_back('{8,  4'b1111, 4'b1101, 1'b0, 1'b1, 4'b0110});
        vecs.push_back('{4,  4'b1111, 4'b1011, 1'b0, 1'b0, 4'b0110});
        vecs.push_back('{1,  4'b1111, 4'b0111, 1'b0, 1'b0, 4'b0110});

        do_reset();
        check("reset", 4'b1110, 1'b0, 1'b0, 4'b0000);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].cycles; k++) begin
                col_drv = vecs[i].col;
                tick();
                check($sformatf("vec%0d_c%0d", i, k), vecs[i].row, vecs[i].valid, vecs[i].held, vecs[i].code);
            end
        end

        // Reset in PRESS_DB: col 0 pressed, sampled on row 3 at the end of the current dwell.
        col_drv = 4'b1110;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("pressdb_c%0d", k), 4'b0111, 1'b0, 1'b0, 4'b0110);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_in_pressdb", 4'b1110, 1'b0, 1'b0, 4'b0000);
        col_drv = 4'b1111;
        for (n = 1; n <= 12; n++) begin
            tick();
            check($sformatf("after_reset_n%0d", n), row_of(n / 4), 1'b0, 1'b0, 4'b0000);
        end

        // Press bounce: detected on row 1 at edge 8, matches for 3 edges, drops at edge 12.
        do_reset();
        for (n = 1; n <= 16; n++) begin
            col_drv = (n >= 5 && n <= 11) ? 4'b1011 : 4'b1111;
            tick();
            ridx = (n < 8) ? n / 4 : (n < 12) ? 1 : 2 + (n - 12) / 4;
            check($sformatf("bounce_n%0d", n), row_of(ridx), 1'b0, 1'b0, 4'b0000);
        end

        // Two zero bits at every sample point are ignored.
        do_reset();
        col_drv = 4'b1001;
        for (n = 1; n <= 12; n++) begin
            tick();
            check($sformatf("multi_n%0d", n), row_of(n / 4), 1'b0, 1'b0, 4'b0000);
        end

        // Long hold: accepted at edge 16, then repeats at +32/+64/+96 only when enabled.
        do_reset();
        pulses = 0;
        for (n = 1; n <= 116; n++) begin
            col_drv = (n >= 5) ? 4'b1011 : 4'b1111;
            tick();
            if (key_valid === 1'b1) pulses++;
            if (n >= 16) begin
                ev = (n == 16) || (REPEAT_ON && ((n - 16) % REP == 0));
                check($sformatf("hold_n%0d", n), 4'b1101, ev, 1'b1, 4'b0110);
            end
        end
        total++;
        if (pulses != (REPEAT_ON ? 4 : 1)) begin
            bad++;
            $display("FAIL hold_pulse_count: got %0d, want %0d", pulses, REPEAT_ON ? 4 : 1);
        end

        // Random presses through the keypad model.
        direct_mode = 1'b0;
        for (int t = 0; t < 24; t++) begin
            key_r = 2'($urandom_range(0, 3));
            key_c = 2'($urandom_range(0, 3));
            p     = $urandom_range(1, 40);
            d     = ((p + 3) / 4) * 4;
            while (((d / 4) - 1) % 4 != int'(key_r)) d += 4;
            a     = d + DB;
            rl    = a + 1 + $urandom_range(0, 110);
            last  = rl + DB + 12;
            key_down = 1'b0;
            do_reset();
            for (n = 1; n <= last; n++) begin
                key_down = (n >= p) && (n < rl);
                tick();
                if (n < d) ridx = n / 4;
                else if (n < rl + DB) ridx = int'(key_r);
                else ridx = int'(key_r) + 1 + (n - rl - DB) / 4;
                ev = (n == a) || (REPEAT_ON && n > a && n < rl && ((n - a) % REP == 0));
                eh = (n >= a) && (n < rl + DB);
                ec = (n >= a) ? {key_r, key_c} : 4'b0000;
                check($sformatf("rand%0d_n%0d", t, n), row_of(ridx), ev, eh, ec);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
